// File: rtl/maxpool_layer_1.sv
// maxpool_layer_1: 2x2, stride-2 max pooling over streamed conv1 feature maps.
// Samples arrive channel-major, then row-major, then by column. A horizontal hold
// register pairs columns, and a half-width line buffer pairs rows. One pooled
// sample is produced per 2x2 window.
//
// Ports:
//   clk          - single clock, all state on rising edge
//   reset_n      - asynchronous active-low reset
//   start_pool1  - one-cycle pulse arming the block for one frame
//   data_valid   - map_in valid this cycle
//   map_in       - signed conv1 sample
//   pooled_out   - signed pooled sample (holds its value between pulses)
//   pool_valid   - pooled_out valid this cycle
//   finish_pool1 - one-cycle pulse, the cycle after the final pool_valid
module maxpool_layer_1 #(
  parameter int unsigned OUT_CHANNELS = 2,
  parameter int unsigned IN_IMG_SIZE  = 24,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start_pool1,
  input  logic                         data_valid,
  input  logic signed [DATA_WIDTH-1:0] map_in,
  output logic signed [DATA_WIDTH-1:0] pooled_out,
  output logic                         pool_valid,
  output logic                         finish_pool1
);

  localparam int unsigned OUT_IMG_SIZE = IN_IMG_SIZE / 2;
  localparam int unsigned POS_W = (IN_IMG_SIZE > 2) ? $clog2(IN_IMG_SIZE) : 2;
  localparam int unsigned CH_W  = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [POS_W-1:0] col, row;
  logic [CH_W-1:0]  ch;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] linebuf [OUT_IMG_SIZE];

  logic                         accept;
  logic                         col_last, row_last, ch_last, last_sample;
  logic [POS_W-2:0]             lb_idx;
  logic signed [DATA_WIDTH-1:0] hmax, vmax, lb_rd;

  assign accept      = (state == RUN) && data_valid;
  assign col_last    = (col == POS_W'(IN_IMG_SIZE - 1));
  assign row_last    = (row == POS_W'(IN_IMG_SIZE - 1));
  assign ch_last     = (ch == CH_W'(OUT_CHANNELS - 1));
  assign last_sample = accept && col_last && row_last && ch_last;

  // Output column index within the pooled row.
  assign lb_idx = col[POS_W-1:1];
  assign lb_rd  = linebuf[lb_idx];

  // Horizontal pair max, then vertical max against the buffered upper row.
  assign hmax = (map_in > hold) ? map_in : hold;
  assign vmax = (lb_rd > hmax) ? lb_rd : hmax;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_pool1) state_next = RUN;
      RUN:     if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position counters: column, then row, then channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if ((state == IDLE) && start_pool1) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
          ch  <= ch_last ? '0 : ch + CH_W'(1);
        end else begin
          row <= row + POS_W'(1);
        end
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

  // Even-column sample waits here for its odd-column partner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              hold <= '0;
    else if (accept && !col[0]) hold <= map_in;
  end

  // Even rows deposit their horizontal maxima for the following odd row.
  always_ff @(posedge clk) begin
    if (accept && col[0] && !row[0]) linebuf[lb_idx] <= hmax;
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pooled_out   <= '0;
      pool_valid   <= 1'b0;
      finish_pool1 <= 1'b0;
    end else begin
      pool_valid   <= accept && col[0] && row[0];
      finish_pool1 <= (state == DONE);
      if (accept && col[0] && row[0]) pooled_out <= vmax;
    end
  end

endmodule

// File: tb/tb_maxpool_layer_1.sv
// Bench for maxpool_layer_1: frames are streamed from a sample table, the expected
// pooled values are computed from the same table by a 2x2 max model and queued,
// and a monitor pops and compares on every pool_valid pulse.
module tb_maxpool_layer_1;

  localparam int unsigned CH   = 2;
  localparam int unsigned IMG  = 24;
  localparam int unsigned DW   = 16;
  localparam int unsigned OIMG = IMG / 2;
  localparam int unsigned NS   = CH * IMG * IMG;
  localparam int unsigned NOUT = CH * OIMG * OIMG;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_pool1 = 1'b0;
  logic data_valid = 1'b0;
  logic signed [DW-1:0] map_in = '0;
  logic signed [DW-1:0] pooled_out;
  logic pool_valid;
  logic finish_pool1;

  always #5 clk = ~clk;

  maxpool_layer_1 #(.OUT_CHANNELS(CH), .IN_IMG_SIZE(IMG), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_pool1 (start_pool1),
    .data_valid  (data_valid),
    .map_in      (map_in),
    .pooled_out  (pooled_out),
    .pool_valid  (pool_valid),
    .finish_pool1(finish_pool1)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;
  int fin_cnt = 0;
  int fin_cyc = -10;
  int last_pv_cyc = -10;
  bit prev_pv = 1'b0;
  bit no_consec = 1'b0;
  bit first_pending = 1'b0;
  logic signed [DW-1:0] first_out = '0;
  logic signed [DW-1:0] last_out = '0;
  logic signed [DW-1:0] exp_val;
  logic signed [DW-1:0] q[$];
  logic signed [DW-1:0] sample[NS];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_out = '0;
      prev_pv  = 1'b0;
    end else begin
      if (pool_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pool_valid: got pooled_out=%0d, required no pulse", pooled_out);
        end else begin
          exp_val = q.pop_front();
          if (pooled_out !== exp_val) begin
            errors++;
            $display("FAIL pooled_out[%0d]: got %0d, required %0d", n_out, pooled_out, exp_val);
          end
        end
        if (no_consec) begin
          checks++;
          if (prev_pv) begin
            errors++;
            $display("FAIL pool_valid_gap: got consecutive pulses at cycle %0d, required isolated", cyc);
          end
        end
        if (first_pending) begin
          first_out     = pooled_out;
          first_pending = 1'b0;
        end
        n_out++;
        last_pv_cyc = cyc;
        last_out    = pooled_out;
      end else begin
        checks++;
        if (pooled_out !== last_out) begin
          errors++;
          $display("FAIL pooled_out_hold: got %0d, required %0d", pooled_out, last_out);
        end
      end
      prev_pv = pool_valid;
      if (finish_pool1) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic fill_ramp(input int off);
    for (int i = 0; i < NS; i++) sample[i] = DW'(off + i);
  endtask

  task automatic push_expected;
    for (int c_h = 0; c_h < CH; c_h++)
      for (int r = 0; r < OIMG; r++)
        for (int c = 0; c < OIMG; c++) begin
          int b;
          b = c_h * IMG * IMG + 2 * r * IMG + 2 * c;
          q.push_back(smax(smax(sample[b], sample[b+1]),
                           smax(sample[b+IMG], sample[b+IMG+1])));
        end
  endtask

  task automatic start_frame;
    first_pending = 1'b1;
    start_pool1 = 1'b1;
    data_valid  = 1'b0;
    tick();
    start_pool1 = 1'b0;
  endtask

  task automatic stream(input bit gapped, input int extra_at, input int count);
    for (int i = 0; i < count; i++) begin
      map_in      = sample[i];
      data_valid  = 1'b1;
      start_pool1 = (i == extra_at);
      tick();
      start_pool1 = 1'b0;
      if (gapped) begin
        data_valid = 1'b0;
        map_in     = 16'sh7FFF;
        tick();
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int base, input bit tail);
    int f0;
    bit seen;
    f0   = fin_cnt;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (fin_cnt != f0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_finish_timeout: got no finish_pool1 in 10 cycles, required one", name);
    end else begin
      checks++;
      if (fin_cyc != last_pv_cyc + 1) begin
        errors++;
        $display("FAIL %s_finish_timing: got cycle %0d, required %0d", name, fin_cyc, last_pv_cyc + 1);
      end
    end
    checks++;
    if (n_out - base != NOUT) begin
      errors++;
      $display("FAIL %s_output_count: got %0d, required %0d", name, n_out - base, NOUT);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d outputs missing, required 0", name, q.size());
    end
    if (tail) begin
      repeat (4) tick();
      checks++;
      if (fin_cnt != f0 + 1) begin
        errors++;
        $display("FAIL %s_finish_pulses: got %0d, required 1", name, fin_cnt - f0);
      end
    end
  endtask

  task automatic test_reset;
    int base;
    repeat (3) tick();
    checks++;
    if (pool_valid !== 1'b0 || finish_pool1 !== 1'b0 || pooled_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_outputs: got pv=%b fin=%b out=%0d, required 0 0 0",
               pool_valid, finish_pool1, pooled_out);
    end
    reset_n = 1'b1;
    tick();
    base = n_out;
    fill_ramp(0);
    stream(1'b0, -1, 30);
    repeat (3) tick();
    checks++;
    if (n_out != base || fin_cnt != 0) begin
      errors++;
      $display("FAIL idle_ignores_data: got %0d outputs %0d finishes, required 0 0", n_out - base, fin_cnt);
    end
  endtask

  task automatic test_ramp;
    int base;
    fill_ramp(0);
    push_expected();
    base = n_out;
    start_frame();
    stream(1'b0, -1, NS);
    wait_finish("ramp", base, 1'b1);
    checks++;
    if (first_out !== 16'sd25) begin
      errors++;
      $display("FAIL ramp_first: got %0d, required 25", first_out);
    end
  endtask

  task automatic test_negatives;
    int base;
    for (int i = 0; i < NS; i++) sample[i] = -16'sd5;
    sample[2 * IMG + 3] = -16'sd1;
    push_expected();
    base = n_out;
    start_frame();
    stream(1'b0, -1, NS);
    wait_finish("negatives", base, 1'b1);
    checks++;
    if (first_out !== -16'sd5) begin
      errors++;
      $display("FAIL negatives_first: got %0d, required -5", first_out);
    end
  endtask

  task automatic test_gapped;
    int base;
    fill_ramp(0);
    push_expected();
    base = n_out;
    no_consec = 1'b1;
    start_frame();
    stream(1'b1, -1, NS);
    wait_finish("gapped", base, 1'b1);
    no_consec = 1'b0;
  endtask

  task automatic test_noise;
    int base;
    fill_ramp(0);
    push_expected();
    base = n_out;
    data_valid = 1'b1;
    map_in     = 16'sh7FFF;
    repeat (5) tick();
    data_valid = 1'b0;
    start_frame();
    stream(1'b0, 100, NS);
    wait_finish("noise", base, 1'b1);
    checks++;
    if (first_out !== 16'sd25) begin
      errors++;
      $display("FAIL noise_first: got %0d, required 25", first_out);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int f0;
    fill_ramp(0);
    push_expected();
    start_frame();
    stream(1'b0, -1, 300);
    reset_n = 1'b0;
    #1;
    checks++;
    if (pool_valid !== 1'b0 || finish_pool1 !== 1'b0 || pooled_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got pv=%b fin=%b out=%0d, required 0 0 0",
               pool_valid, finish_pool1, pooled_out);
    end
    q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    base = n_out;
    f0   = fin_cnt;
    stream(1'b0, -1, 60);
    repeat (4) tick();
    checks++;
    if (n_out != base || fin_cnt != f0) begin
      errors++;
      $display("FAIL reset_mid_abandon: got %0d outputs %0d finishes, required 0 0",
               n_out - base, fin_cnt - f0);
    end
    push_expected();
    base = n_out;
    start_frame();
    stream(1'b0, -1, NS);
    wait_finish("reset_mid_rerun", base, 1'b1);
  endtask

  task automatic test_back_to_back;
    int base;
    fill_ramp(0);
    push_expected();
    base = n_out;
    start_frame();
    stream(1'b0, -1, NS);
    wait_finish("b2b_first", base, 1'b0);
    checks++;
    if (first_out !== 16'sd25) begin
      errors++;
      $display("FAIL b2b_first_value: got %0d, required 25", first_out);
    end
    fill_ramp(1000);
    push_expected();
    base = n_out;
    start_frame();
    stream(1'b0, -1, NS);
    wait_finish("b2b_second", base, 1'b1);
    checks++;
    if (first_out !== 16'sd1025) begin
      errors++;
      $display("FAIL b2b_second_value: got %0d, required 1025", first_out);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negatives();
    test_gapped();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
